amp_adc_sequencer: RTL and testbench

AMP_ADC_SEQUENCER -- requirements
Module: amp_adc_sequencer

---
 rtl/amp_adc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_amp_adc_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amp_adc_sequencer.sv
// Sequences a preamp gain write and ADC sample frames over a shared SPI bus.
// Bus timing advances only on clockenable ticks (one tick = one SCK half-period).
//
// state    | meaning
// IDLE     | bus quiet; pick gain write (priority) or ADC frame
// AMP_XFER | preamp selected, 8 gain bits shifted out MSB first
// AMP_END  | preamp deselected for one tick, gain_ack pulses
// CONV     | ad_conv high for one tick
// ADC_XFER | 34 SCK periods, MISO captured into the two sample shifters
// ADC_END  | samples published, sample_valid pulses
module amp_adc_sequencer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        clockenable,
    input  logic [3:0]  gain_a,
    input  logic [3:0]  gain_b,
    input  logic        gain_load,
    input  logic        sample_req,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        ampcs,
    output logic        ampshdn,
    output logic        ad_conv,
    output logic        busy,
    output logic        gain_ack,
    output logic        sample_valid,
    output logic [13:0] sample_a,
    output logic [13:0] sample_b
);

    typedef enum logic [2:0] {IDLE, AMP_XFER, AMP_END, CONV, ADC_XFER, ADC_END} state_t;

    state_t      state, state_nxt;
    logic [6:0]  tick_cnt;
    logic [7:0]  gain_reg;
    logic [7:0]  gain_next;
    logic [6:0]  amp_shift;
    logic [13:0] shift_a, shift_b;
    logic        gain_pend, sample_pend;
    logic        enter_amp, enter_conv;
    logic        tick_last;
    logic [5:0]  rise_idx;

    // A gain_load in the entry cycle is sent rather than lost, since it merges into the flag being cleared.
    assign gain_next  = gain_load ? {gain_b, gain_a} : gain_reg;
    assign enter_amp  = clockenable && (state == IDLE) && gain_pend;
    assign enter_conv = clockenable && (state == IDLE) && !gain_pend && sample_pend;
    assign tick_last  = (tick_cnt == 7'd0);
    assign rise_idx   = 6'((7'd69 - tick_cnt) >> 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else if (clockenable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gain_pend)        state_nxt = AMP_XFER;
                else if (sample_pend) state_nxt = CONV;
            end
            AMP_XFER: if (tick_last) state_nxt = AMP_END;
            AMP_END:  state_nxt = IDLE;
            CONV:     state_nxt = ADC_XFER;
            ADC_XFER: if (tick_last) state_nxt = ADC_END;
            ADC_END:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        ampcs   = (state != AMP_XFER);
        ad_conv = (state == CONV);
        ampshdn = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            gain_pend   <= 1'b1;
            sample_pend <= 1'b0;
            gain_reg    <= 8'h22;
        end else begin
            if (gain_load) gain_reg <= {gain_b, gain_a};
            if (enter_amp)      gain_pend <= 1'b0;
            else if (gain_load) gain_pend <= 1'b1;
            if (enter_conv)      sample_pend <= 1'b0;
            else if (sample_req) sample_pend <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt     <= 7'd0;
            amp_shift    <= 7'd0;
            shift_a      <= 14'd0;
            shift_b      <= 14'd0;
            spi_sck      <= 1'b0;
            spi_mosi     <= 1'b0;
            gain_ack     <= 1'b0;
            sample_valid <= 1'b0;
            sample_a     <= 14'd0;
            sample_b     <= 14'd0;
        end else begin
            gain_ack     <= 1'b0;
            sample_valid <= 1'b0;
            if (clockenable) begin
                case (state)
                    IDLE: begin
                        if (enter_amp) begin
                            amp_shift <= gain_next[6:0];
                            spi_mosi  <= gain_next[7];
                            spi_sck   <= 1'b0;
                            tick_cnt  <= 7'd15;
                        end else if (enter_conv) begin
                            shift_a <= 14'd0;
                            shift_b <= 14'd0;
                        end
                    end
                    AMP_XFER: begin
                        if (tick_last) begin
                            spi_sck  <= 1'b0;
                            spi_mosi <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt - 7'd1;
                            spi_sck  <= ~spi_sck;
                            if (spi_sck) begin
                                spi_mosi  <= amp_shift[6];
                                amp_shift <= {amp_shift[5:0], 1'b0};
                            end
                        end
                    end
                    AMP_END: gain_ack <= 1'b1;
                    CONV:    tick_cnt <= 7'd67;
                    ADC_XFER: begin
                        spi_sck <= ~spi_sck;
                        if (!tick_last) tick_cnt <= tick_cnt - 7'd1;
                        if (!spi_sck) begin
                            if (rise_idx >= 6'd3 && rise_idx <= 6'd16)
                                shift_a <= {shift_a[12:0], spi_miso};
                            else if (rise_idx >= 6'd19 && rise_idx <= 6'd32)
                                shift_b <= {shift_b[12:0], spi_miso};
                        end
                    end
                    ADC_END: begin
                        sample_a     <= shift_a;
                        sample_b     <= shift_b;
                        sample_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_amp_adc_sequencer.sv
// Directed bench for amp_adc_sequencer: a bus monitor records MOSI bits, SCK
// rises and pulses, and an ADC slave model returns the programmed sample words.
module tb_amp_adc_sequencer;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        clockenable = 1'b0;
    logic [3:0]  gain_a = 4'h0, gain_b = 4'h0;
    logic        gain_load = 1'b0, sample_req = 1'b0, spi_miso = 1'b0;
    logic        spi_sck, spi_mosi, ampcs, ampshdn, ad_conv, busy, gain_ack, sample_valid;
    logic [13:0] sample_a, sample_b;

    int tests = 0, fails = 0;
    logic        ce_hold = 1'b0;
    logic [13:0] miso_a = 14'h2ABC, miso_b = 14'h1555;

    logic [7:0] amp_bits;
    int amp_rises, adc_rises, ack_cnt, valid_cnt, conv_cyc, cs_low_cyc, viol;
    int cyc = 0, ack_at, valid_at;
    logic prev_sck = 1'b0;

    amp_adc_sequencer dut (
        .clock(clock), .resetn(resetn), .clockenable(clockenable),
        .gain_a(gain_a), .gain_b(gain_b), .gain_load(gain_load),
        .sample_req(sample_req), .spi_miso(spi_miso),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .ampcs(ampcs), .ampshdn(ampshdn),
        .ad_conv(ad_conv), .busy(busy), .gain_ack(gain_ack),
        .sample_valid(sample_valid), .sample_a(sample_a), .sample_b(sample_b)
    );

    always #5 clock = ~clock;

    // clockenable high on every second rising edge unless frozen
    initial forever begin
        @(negedge clock);
        clockenable = ce_hold ? 1'b0 : ~clockenable;
    end

    // Bus monitor and ADC slave: MISO presents the bit for the upcoming SCK rise
    initial forever begin
        int r;
        @(negedge clock);
        cyc++;
        if (spi_sck && !prev_sck) begin
            if (!ampcs) begin
                amp_bits = {amp_bits[6:0], spi_mosi};
                amp_rises++;
            end else begin
                adc_rises++;
                if (spi_mosi) viol++;
            end
        end
        if (spi_sck != prev_sck && ad_conv) viol++;
        if (!ampcs && ad_conv) viol++;
        if (ad_conv) begin
            conv_cyc++;
            adc_rises = 0;
        end
        if (!ampcs) cs_low_cyc++;
        if (gain_ack) begin ack_cnt++; ack_at = cyc; end
        if (sample_valid) begin valid_cnt++; valid_at = cyc; end
        prev_sck = spi_sck;
        r = adc_rises + 1;
        if (r >= 3 && r <= 16)       spi_miso = miso_a[16 - r];
        else if (r >= 19 && r <= 32) spi_miso = miso_b[32 - r];
        else                         spi_miso = 1'b1;
    end

    task automatic clear_mon();
        @(posedge clock);
        amp_bits = 8'h00; amp_rises = 0; adc_rises = 0; ack_cnt = 0; valid_cnt = 0;
        conv_cyc = 0; cs_low_cyc = 0; viol = 0; ack_at = 0; valid_at = 0;
    endtask

    task automatic pulse(input logic gl, input logic sr);
        @(negedge clock);
        gain_load = gl; sample_req = sr;
        @(negedge clock);
        gain_load = 1'b0; sample_req = 1'b0;
    endtask

    task automatic wait_done(input int acks, input int valids, input string name);
        int n = 0;
        while ((ack_cnt < acks || valid_cnt < valids) && n < 1500) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (n >= 1500) begin
            fails++;
            $display("FAIL %s timeout: ack=%0d valid=%0d, required ack=%0d valid=%0d",
                     name, ack_cnt, valid_cnt, acks, valids);
        end
        repeat (6) @(negedge clock);
    endtask

    task automatic wait_rises(input bit amp, input int n_rise, input string name);
        int n = 0;
        while ((amp ? amp_rises : adc_rises) < n_rise && n < 1000) begin
            @(negedge clock);
            n++;
        end
        tests++;
        if (n >= 1000) begin
            fails++;
            $display("FAIL %s rise timeout: got %0d, required %0d", name,
                     amp ? amp_rises : adc_rises, n_rise);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        tests++;
        if ({spi_sck, spi_mosi, ampcs, ampshdn, ad_conv, busy, gain_ack, sample_valid} !== 8'b0010_0000) begin
            fails++;
            $display("FAIL reset_outputs: got %b, required 00100000",
                     {spi_sck, spi_mosi, ampcs, ampshdn, ad_conv, busy, gain_ack, sample_valid});
        end
        tests++;
        if ({sample_a, sample_b} !== 28'd0) begin
            fails++;
            $display("FAIL reset_samples: got %h/%h, required 0/0", sample_a, sample_b);
        end
    endtask

    task automatic test_auto_gain();
        clear_mon();
        @(negedge clock);
        resetn = 1'b1;
        wait_done(1, 0, "auto_gain");
        tests++;
        if (amp_bits !== 8'h22) begin fails++; $display("FAIL auto_gain_bits: got %h, required 22", amp_bits); end
        tests++;
        if (amp_rises !== 8) begin fails++; $display("FAIL auto_gain_rises: got %0d, required 8", amp_rises); end
        tests++;
        if (cs_low_cyc !== 32) begin fails++; $display("FAIL auto_gain_cs_low: got %0d cycles, required 32", cs_low_cyc); end
        tests++;
        if ({ack_cnt, valid_cnt} !== {32'd1, 32'd0}) begin
            fails++; $display("FAIL auto_gain_pulses: ack=%0d valid=%0d, required 1/0", ack_cnt, valid_cnt);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL auto_gain_busy: got %b, required 0", busy); end
    endtask

    task automatic test_gain_write();
        clear_mon();
        gain_a = 4'h5; gain_b = 4'h3;
        pulse(1'b1, 1'b0);
        wait_done(1, 0, "gain_write");
        tests++;
        if (amp_bits !== 8'h35) begin fails++; $display("FAIL gain_write_bits: got %h, required 35", amp_bits); end
        tests++;
        if ({ack_cnt, adc_rises, conv_cyc} !== {32'd1, 32'd0, 32'd0}) begin
            fails++; $display("FAIL gain_write_only: ack=%0d adc_rises=%0d conv=%0d, required 1/0/0",
                              ack_cnt, adc_rises, conv_cyc);
        end
    endtask

    task automatic test_sample();
        logic [13:0] va [3] = '{14'h2ABC, 14'h2000, 14'h0001};
        logic [13:0] vb [3] = '{14'h1555, 14'h1FFF, 14'h3FFE};
        for (int i = 0; i < 3; i++) begin
            miso_a = va[i]; miso_b = vb[i];
            clear_mon();
            pulse(1'b0, 1'b1);
            wait_done(0, 1, "sample");
            tests++;
            if ({sample_a, sample_b} !== {va[i], vb[i]}) begin
                fails++; $display("FAIL sample_%0d_data: got %h/%h, required %h/%h", i, sample_a, sample_b, va[i], vb[i]);
            end
            tests++;
            if ({adc_rises, conv_cyc, valid_cnt, ack_cnt, cs_low_cyc, viol} !==
                {32'd34, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0}) begin
                fails++;
                $display("FAIL sample_%0d_frame: rises=%0d conv=%0d valid=%0d ack=%0d cs_low=%0d viol=%0d, required 34/2/1/0/0/0",
                         i, adc_rises, conv_cyc, valid_cnt, ack_cnt, cs_low_cyc, viol);
            end
        end
    endtask

    task automatic test_both_same_cycle();
        miso_a = 14'h0F0F; miso_b = 14'h30C3;
        clear_mon();
        gain_a = 4'hA; gain_b = 4'hC;
        pulse(1'b1, 1'b1);
        wait_done(1, 1, "both");
        tests++;
        if (amp_bits !== 8'hCA) begin fails++; $display("FAIL both_bits: got %h, required ca", amp_bits); end
        tests++;
        if (!(ack_at < valid_at)) begin fails++; $display("FAIL both_order: ack at %0d, valid at %0d, required ack first", ack_at, valid_at); end
        tests++;
        if ({amp_rises, adc_rises, cs_low_cyc, viol} !== {32'd8, 32'd34, 32'd32, 32'd0}) begin
            fails++; $display("FAIL both_bus: amp_rises=%0d adc_rises=%0d cs_low=%0d viol=%0d, required 8/34/32/0",
                              amp_rises, adc_rises, cs_low_cyc, viol);
        end
        tests++;
        if ({sample_a, sample_b} !== {14'h0F0F, 14'h30C3}) begin
            fails++; $display("FAIL both_data: got %h/%h, required 0f0f/30c3", sample_a, sample_b);
        end
    endtask

    task automatic test_merge();
        clear_mon();
        @(negedge clock);
        gain_a = 4'h1; gain_b = 4'h4; gain_load = 1'b1; sample_req = 1'b1;
        @(negedge clock);
        gain_a = 4'h7; gain_b = 4'hE;
        @(negedge clock);
        gain_load = 1'b0; sample_req = 1'b0;
        wait_done(1, 1, "merge");
        repeat (300) @(negedge clock);
        tests++;
        if ({ack_cnt, valid_cnt} !== {32'd1, 32'd1}) begin
            fails++; $display("FAIL merge_count: ack=%0d valid=%0d, required 1/1", ack_cnt, valid_cnt);
        end
        tests++;
        if (amp_bits !== 8'hE7) begin fails++; $display("FAIL merge_latest: got %h, required e7", amp_bits); end
    endtask

    task automatic test_busy_latch();
        clear_mon();
        pulse(1'b0, 1'b1);
        wait_rises(1'b0, 5, "busy_latch");
        gain_a = 4'h1; gain_b = 4'h8;
        pulse(1'b1, 1'b0);
        wait_done(1, 1, "busy_latch");
        tests++;
        if (!(valid_at < ack_at) || amp_bits !== 8'h81) begin
            fails++; $display("FAIL busy_latch: valid at %0d ack at %0d bits %h, required valid first and 81",
                              valid_at, ack_at, amp_bits);
        end
    endtask

    task automatic test_freeze();
        logic [3:0] snap;
        clear_mon();
        gain_a = 4'h6; gain_b = 4'h9;
        pulse(1'b1, 1'b0);
        wait_rises(1'b1, 3, "freeze");
        ce_hold = 1'b1;
        repeat (2) @(negedge clock);
        snap = {spi_sck, spi_mosi, ampcs, busy};
        repeat (12) @(negedge clock);
        tests++;
        if ({spi_sck, spi_mosi, ampcs, busy} !== snap || amp_rises !== 3) begin
            fails++; $display("FAIL freeze_hold: got %b rises %0d, required %b rises 3",
                              {spi_sck, spi_mosi, ampcs, busy}, amp_rises, snap);
        end
        ce_hold = 1'b0;
        wait_done(1, 0, "freeze");
        tests++;
        if (amp_bits !== 8'h96) begin fails++; $display("FAIL freeze_bits: got %h, required 96", amp_bits); end
    endtask

    task automatic test_reset_mid();
        miso_a = 14'h2ABC; miso_b = 14'h1555;
        clear_mon();
        pulse(1'b0, 1'b1);
        wait_rises(1'b0, 15, "reset_mid");
        #2 resetn = 1'b0;
        #1;
        tests++;
        if ({spi_sck, spi_mosi, ampcs, ad_conv, busy, gain_ack, sample_valid} !== 7'b0010000 ||
            {sample_a, sample_b} !== 28'd0) begin
            fails++; $display("FAIL reset_mid_immediate: got %b %h/%h, required 0010000 0/0",
                              {spi_sck, spi_mosi, ampcs, ad_conv, busy, gain_ack, sample_valid}, sample_a, sample_b);
        end
        repeat (3) @(negedge clock);
        clear_mon();
        @(negedge clock);
        resetn = 1'b1;
        wait_done(1, 0, "reset_mid");
        repeat (300) @(negedge clock);
        tests++;
        if (amp_bits !== 8'h22 || valid_cnt !== 0 || adc_rises !== 0 || {sample_a, sample_b} !== 28'd0) begin
            fails++; $display("FAIL reset_mid_after: bits %h valid=%0d adc_rises=%0d samples %h/%h, required 22/0/0/0",
                              amp_bits, valid_cnt, adc_rises, sample_a, sample_b);
        end
    endtask

    initial begin
        test_reset();
        test_auto_gain();
        test_gain_write();
        test_sample();
        test_both_same_cycle();
        test_merge();
        test_busy_latch();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
